instr_encoder_loader: RTL and testbench

Packs register-field operands into 32-bit instruction words (5-bit opcode plus 27-bit payload laid out per addressing mode I/J/R/J*). It is the inverse of the processor's addressing-mode field splitter. Sits between the program source (test loader or boot controller) and instruction memory. Accepts one instruction per valid/ready handshake and writes the encoded word to consecutive instruction-memory addresses through an ack-based write port.

---
 rtl/instr_encoder_loader_pkg.sv | 12 +
 rtl/instr_encoder_loader_packer.sv | 26 ++
 rtl/instr_encoder_loader.sv | 83 ++++++++
 tb/tb_instr_encoder_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: shared field widths, addressing-mode encodings and loader FSM states.
package instr_encoder_loader_pkg;
    localparam int OPCODE_W  = 5;
    localparam int REG_W     = 9;
    localparam int PAYLOAD_W = 27;
    localparam int INSTR_W   = 32;
    localparam logic [1:0] MODO_I  = 2'b00;
    localparam logic [1:0] MODO_J  = 2'b01;
    localparam logic [1:0] MODO_R  = 2'b10;
    localparam logic [1:0] MODO_JS = 2'b11;
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;
endpackage

// File: rtl/instr_encoder_loader_packer.sv
// instr_field_packer: packs opcode and register fields into a 32-bit word by addressing mode.
// Flags a nonzero field that the mode drops when CHECK is set.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
#(
    parameter bit CHECK = 1'b0
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [1:0]          modo,
    input  logic [REG_W-1:0]    ra,
    input  logic [REG_W-1:0]    rb,
    input  logic [REG_W-1:0]    rc,
    output logic [INSTR_W-1:0]  word,
    output logic                unused_nz
);
    logic [PAYLOAD_W-1:0] payload;
    always_comb begin
        payload   = modo == MODO_I ? {ra, rb, 9'd0} :
                    modo == MODO_J ? {rb, 18'd0} :
                    modo == MODO_R ? {rc, ra, rb} : {rc, rb, 9'd0};
        unused_nz = CHECK && (modo == MODO_I ? |rc :
                              modo == MODO_J ? (|ra || |rc) :
                              modo == MODO_JS ? |ra : 1'b0);
        word      = {opcode, payload};
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts operand bundles and writes encoded words to consecutive memory addresses.
// Optional ENCODER_FIELD_CHECK_EN enables the sticky erro flag for nonzero unused fields.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0,
    parameter int DEPTH  = 256
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OPCODE_W-1:0]          opcode,
    input  logic [1:0]                   modo,
    input  logic [REG_W-1:0]             ra,
    input  logic [REG_W-1:0]             rb,
    input  logic [REG_W-1:0]             rc,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [INSTR_W-1:0]           mem_wdata,
    input  logic                         mem_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         erro
);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef ENCODER_FIELD_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    state_t state, state_nx;
    logic [INSTR_W-1:0] word;
    logic [CNT_W-1:0] count_inc;
    logic bad, accept, done;

    instr_field_packer #(.CHECK(CHECK)) u_packer (
        .opcode(opcode), .modo(modo), .ra(ra), .rb(rb), .rc(rc),
        .word(word), .unused_nz(bad)
    );

    assign count_inc = count + 1'b1;
    assign accept    = state == IDLE && in_valid;
    assign done      = state == WRITE && mem_ack;

    always_comb begin
        in_ready = state == IDLE;
        mem_we   = state == WRITE;
        full     = state == FULL;
        state_nx = clear  ? IDLE :
                   accept ? WRITE :
                   done   ? (count_inc == CNT_W'(DEPTH) ? FULL : IDLE) : state;
    end

    // clear outranks a same-cycle ack, so an aborted write never advances address or count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_addr  <= ADDR_W'(BASE);
            mem_wdata <= '0;
            count     <= '0;
            erro      <= 1'b0;
        end else begin
            state <= state_nx;
            if (clear) begin
                mem_addr <= ADDR_W'(BASE);
                count    <= '0;
                erro     <= 1'b0;
            end else begin
                if (accept) begin
                    mem_wdata <= word;
                    erro      <= erro | bad;
                end
                if (done) begin
                    mem_addr <= mem_addr + 1'b1;
                    count    <= count_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed plus randomized checks of the encoder/loader against a transaction model.
module tb_instr_encoder_loader;
    localparam int DEPTH = 4;
`ifdef ENCODER_FIELD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clock = 1'b0, reset_n = 1'b0, clear = 1'b0, in_valid = 1'b0, mem_ack = 1'b0;
    logic [4:0] opcode = '0;
    logic [1:0] modo = '0;
    logic [8:0] ra = '0, rb = '0, rc = '0;
    logic in_ready, mem_we, full, erro;
    logic [7:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0] count;
    int checks = 0, errors = 0;
    int exp_addr = 0, exp_count = 0;
    bit exp_erro = 1'b0;

    instr_encoder_loader #(.ADDR_W(8), .BASE(0), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .modo(modo), .ra(ra), .rb(rb), .rc(rc),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .count(count), .full(full), .erro(erro)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] enc(input int op, input int m, input int a, input int b, input int c);
        int w;
        w = op * 2**27;
        if (m == 0) w += a * 2**18 + b * 2**9;
        else if (m == 1) w += b * 2**18;
        else if (m == 2) w += c * 2**18 + a * 2**9 + b;
        else w += c * 2**18 + b * 2**9;
        return 32'(w);
    endfunction

    function automatic bit dropped(input int m, input int a, input int c);
        return (m == 0 && c != 0) || (m == 1 && (a != 0 || c != 0)) || (m == 3 && a != 0);
    endfunction

    task automatic present(input int op, input int m, input int a, input int b, input int c);
        int n = 0;
        while (!in_ready && n < 20) begin step; n++; end
        check("ready_before", in_ready, 1);
        opcode = 5'(op); modo = 2'(m); ra = 9'(a); rb = 9'(b); rc = 9'(c);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        opcode = 5'($urandom); ra = 9'($urandom); rb = 9'($urandom); rc = 9'($urandom);
        if (CHK && dropped(m, a, c)) exp_erro = 1'b1;
    endtask

    task automatic send(input int op, input int m, input int a, input int b, input int c,
                        input int d, input logic [31:0] ew);
        present(op, m, a, b, c);
        check("we_on", mem_we, 1);
        check("ready_busy", in_ready, 0);
        check("addr", mem_addr, 32'(exp_addr));
        check("wdata", mem_wdata, ew);
        repeat (d) begin
            step;
            check("we_hold", mem_we, 1);
            check("addr_hold", mem_addr, 32'(exp_addr));
            check("wdata_hold", mem_wdata, ew);
            check("ready_hold", in_ready, 0);
        end
        mem_ack = 1'b1;
        step;
        mem_ack = 1'b0;
        exp_addr++;
        exp_count++;
        check("we_off", mem_we, 0);
        check("count", count, 32'(exp_count));
        check("addr_next", mem_addr, 32'(exp_addr));
        check("full", full, 32'(exp_count == DEPTH));
        check("ready_after", in_ready, 32'(exp_count != DEPTH));
        check("erro", erro, 32'(exp_erro));
    endtask

    task automatic do_clear;
        clear = 1'b1;
        step;
        clear = 1'b0;
        exp_addr = 0; exp_count = 0; exp_erro = 1'b0;
        check("clr_addr", mem_addr, 0);
        check("clr_count", count, 0);
        check("clr_ready", in_ready, 1);
        check("clr_full", full, 0);
        check("clr_erro", erro, 0);
    endtask

    initial begin
        step;
        check("rst_ready", in_ready, 1);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_erro", erro, 0);
        reset_n = 1'b1;
        step;
        send(3, 2, 2, 3, 1, 0, 32'h18040403);
        send(1, 0, 5, 7, 0, 0, 32'h08140E00);
        send(2, 1, 0, 'h1FF, 0, 5, 32'h17FC0000);
        send(4, 3, 0, 1, 1, 0, 32'h20040200);
        in_valid = 1'b1;
        repeat (5) begin
            step;
            check("full_we", mem_we, 0);
            check("full_ready", in_ready, 0);
            check("full_count", count, 4);
            check("full_flag", full, 1);
        end
        in_valid = 1'b0;
        do_clear;
        mem_ack = 1'b1;
        repeat (3) step;
        mem_ack = 1'b0;
        check("idle_ack_count", count, 0);
        check("idle_ack_addr", mem_addr, 0);
        check("idle_ack_we", mem_we, 0);
        send(2, 1, 1, 5, 0, 1, 32'h10000000 | (32'd5 << 18));
        send(7, 2, 9, 8, 6, 2, enc(7, 2, 9, 8, 6));
        present(5, 0, 1, 2, 0);
        check("abort_we_before", mem_we, 1);
        clear = 1'b1; mem_ack = 1'b1;
        step;
        clear = 1'b0; mem_ack = 1'b0;
        exp_addr = 0; exp_count = 0; exp_erro = 1'b0;
        check("abort_we", mem_we, 0);
        check("abort_count", count, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_erro", erro, 0);
        check("abort_ready", in_ready, 1);
        send(6, 0, 3, 4, 0, 0, enc(6, 0, 3, 4, 0));
        present(6, 1, 0, 9, 0);
        #2 reset_n = 1'b0;
        #1 check("async_we", mem_we, 0);
        check("async_addr", mem_addr, 0);
        check("async_count", count, 0);
        reset_n = 1'b1;
        exp_addr = 0; exp_count = 0; exp_erro = 1'b0;
        step;
        check("post_rst_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) begin
            int op, m, a, b, c;
            if (exp_count == DEPTH || $urandom_range(0, 7) == 0) do_clear;
            op = int'($urandom_range(0, 31));
            m = int'($urandom_range(0, 3));
            a = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 511)) : 0;
            b = int'($urandom_range(0, 511));
            c = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 511)) : 0;
            if (m == 2) begin a = int'($urandom_range(0, 511)); c = int'($urandom_range(0, 511)); end
            send(op, m, a, b, c, int'($urandom_range(0, 3)), enc(op, m, a, b, c));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
